// File: rtl/csr_trap_if.sv
// Core-side bundle between decode/execute, the PC mux and the machine-mode CSR/trap unit.
// The master drives instruction context and interrupt lines; the slave returns CSR data and redirects.
interface csr_trap_if;
  logic [31:0] pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;
  logic        is_mret;
  logic        redirect_busy;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] epc;
  logic        epc_taken;

  modport master (
    output pc, csr_addr, csr_wdata, csr_op, is_mret, redirect_busy, timer_irq, ext_irq,
    input  csr_rdata, epc, epc_taken
  );

  modport slave (
    input  pc, csr_addr, csr_wdata, csr_op, is_mret, redirect_busy, timer_irq, ext_irq,
    output csr_rdata, epc, epc_taken
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: takes timer/external interrupts at instruction
// boundaries, executes MRET, and drives the PC mux redirect.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  csr_trap_if.slave  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  // Only architecturally writable bits are stored; the rest are constant zero on read.
  logic                       mstatus_mie_q, mstatus_mie_d;
  logic                       mstatus_mpie_q, mstatus_mpie_d;
  logic                       mie_mtie_q, mie_mtie_d;
  logic                       mie_meie_q, mie_meie_d;
  logic [31:2]                mtvec_q, mtvec_d;
  logic [31:2]                mepc_q, mepc_d;
  logic [31:0]                mcause_q, mcause_d;
  logic [IRQ_SYNC_STAGES-1:0] sync_q, sync_d;

  csr_op_e     op;
  logic        csr_we;
  logic [31:0] rdata;
  logic [31:0] wval;
  logic        mip_mtip;
  logic        mip_meip;
  logic        meip_en;
  logic        irq_go;
  logic [31:0] pc_plus4;
  logic        unused_pc_bits;

  assign op       = csr_op_e'(bus.csr_op);
  assign csr_we   = (op != OP_NONE);
  assign mip_mtip = bus.timer_irq;
  assign mip_meip = sync_q[IRQ_SYNC_STAGES-1];
  assign meip_en  = mie_meie_q & mip_meip;
  assign irq_go   = mstatus_mie_q & (meip_en | (mie_mtie_q & mip_mtip))
                  & ~bus.redirect_busy & ~bus.is_mret;
  assign pc_plus4 = bus.pc + 32'd4;
  assign unused_pc_bits = ^pc_plus4[1:0];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rdata = '0;
    unique case (bus.csr_addr)
      ADDR_MSTATUS: rdata = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      ADDR_MIE:     rdata = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
      ADDR_MTVEC:   rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:    rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:  rdata = mcause_q;
      ADDR_MIP:     rdata = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
      default:      rdata = '0;
    endcase
  end

  // Read-modify-write operand: the pre-write value is exactly what csr_rdata returns.
  always_comb begin
    wval = rdata;
    unique case (op)
      OP_WRITE: wval = bus.csr_wdata;
      OP_SET:   wval = rdata | bus.csr_wdata;
      OP_CLEAR: wval = rdata & ~bus.csr_wdata;
      default:  wval = rdata;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    sync_d         = {sync_q[IRQ_SYNC_STAGES-2:0], bus.ext_irq};

    if (csr_we) begin
      unique case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        ADDR_MIE: begin
          mie_mtie_d = wval[7];
          mie_meie_d = wval[11];
        end
        ADDR_MTVEC:  mtvec_d  = wval[31:2];
        ADDR_MEPC:   mepc_d   = wval[31:2];
        ADDR_MCAUSE: mcause_d = wval;
        default: ;
      endcase
    end

    // Trap and MRET sequencing is applied last so it overrides a same-cycle software write.
    if (irq_go) begin
      mepc_d         = pc_plus4[31:2];
      mcause_d       = meip_en ? CAUSE_EXT : CAUSE_TIMER;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (bus.is_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET[31:2];
      mepc_q         <= '0;
      mcause_q       <= '0;
      sync_q         <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      sync_q         <= sync_d;
    end
  end

  // The redirect is gated by rst_n so a decoded MRET cannot steer the PC while reset is held.
  assign bus.csr_rdata = rdata;
  assign bus.epc       = irq_go ? {mtvec_q, 2'b00} : {mepc_q, 2'b00};
  assign bus.epc_taken = rst_n & (irq_go | bus.is_mret);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a driver pushes model expectations each cycle and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_csr_trap_unit;

  localparam int unsigned STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  csr_trap_if bus ();

  csr_trap_unit #(.MTVEC_RESET(32'h0000_0100), .IRQ_SYNC_STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        taken;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: architectural CSR values, already masked to their readable bits.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
  bit          ext_hist[$];

  function automatic void model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0;
    ext_hist.delete();
    for (int i = 0; i < STAGES; i++) ext_hist.push_back(1'b0);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic [31:0] mip);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return mip;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".rdata"}, bus.csr_rdata, e.rdata);
      check({e.tag, ".taken"}, {31'b0, bus.epc_taken}, {31'b0, e.taken});
      check({e.tag, ".epc_known"}, {31'b0, $isunknown(bus.epc)}, 32'h0);
      if (e.taken) check({e.tag, ".epc"}, bus.epc, e.epc);
    end
  end

  task automatic cyc(input logic r, input logic [31:0] pc, input logic [11:0] a,
                     input logic [31:0] wd, input logic [1:0] op, input logic mret,
                     input logic busy, input logic tmr, input logic ext, input string tag);
    exp_t        e;
    logic [31:0] mip, old, nv, old_ms;
    bit          meip, irq, ext_win;
    @(posedge clk);
    #1;
    rst_n = r; bus.pc = pc; bus.csr_addr = a; bus.csr_wdata = wd; bus.csr_op = op;
    bus.is_mret = mret; bus.redirect_busy = busy; bus.timer_irq = tmr; bus.ext_irq = ext;
    if (!r) model_reset();
    meip    = ext_hist[STAGES-1];
    mip     = (32'(tmr) << 7) | (32'(meip) << 11);
    ext_win = m_mie[11] && meip;
    irq     = m_mstatus[3] && (ext_win || (m_mie[7] && tmr)) && !busy && !mret;
    old     = model_read(a, mip);
    e.tag   = tag;
    e.rdata = old;
    e.taken = r && (irq || mret);
    e.epc   = irq ? m_mtvec : m_mepc;
    exp_q.push_back(e);
    if (!r) begin
      model_reset();
    end else begin
      old_ms = m_mstatus;
      case (op)
        2'b01: nv = wd;
        2'b10: nv = old | wd;
        2'b11: nv = old & ~wd;
        default: nv = old;
      endcase
      if (op != 2'b00) begin
        case (a)
          12'h300: m_mstatus = nv & 32'h88;
          12'h304: m_mie     = nv & 32'h880;
          12'h305: m_mtvec   = nv & ~32'h3;
          12'h341: m_mepc    = nv & ~32'h3;
          12'h342: m_mcause  = nv;
          default: ;
        endcase
      end
      if (irq) begin
        m_mepc    = (pc + 32'd4) & ~32'h3;
        m_mcause  = ext_win ? 32'h8000_000B : 32'h8000_0007;
        m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
      end else if (mret) begin
        m_mstatus = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
      end
      void'(ext_hist.pop_back());
      ext_hist.push_front(ext);
    end
  endtask

  // Shorthands: idle/read cycle and CSR-op cycle with given interrupt levels.
  task automatic rd(input logic [11:0] a, input logic tmr, input logic ext, input string tag);
    cyc(1'b1, 32'h40, a, 32'h0, 2'b00, 1'b0, 1'b0, tmr, ext, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic [1:0] op,
                    input logic tmr, input logic ext, input string tag);
    cyc(1'b1, 32'h40, a, wd, op, 1'b0, 1'b0, tmr, ext, tag);
  endtask

  logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h000};
  logic [11:0] six   [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};

  initial begin
    logic tmr, ext;
    model_reset();
    // 1: reset state; is_mret held during reset must not redirect
    cyc(1'b0, 32'h0, 12'h305, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold");
    cyc(1'b0, 32'h0, 12'h300, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold2");
    for (int i = 0; i < 6; i++) rd(six[i], 1'b0, 1'b0, $sformatf("reset_rd%0d", i));

    // 2: external interrupt, 2-edge synchronizer latency
    wr(12'h300, 32'h8, 2'b01, 1'b0, 1'b0, "wr_mstatus");
    wr(12'h304, 32'h800, 2'b01, 1'b0, 1'b0, "wr_mie");
    for (int i = 0; i < 3; i++) rd(12'h000, 1'b0, 1'b1, $sformatf("ext_wait%0d", i));
    rd(12'h341, 1'b0, 1'b1, "trap_mepc");
    rd(12'h342, 1'b0, 1'b1, "trap_mcause");
    rd(12'h300, 1'b0, 1'b1, "trap_mstatus");

    // 3: MRET returns to mepc and restores MIE
    cyc(1'b1, 32'h200, 12'h000, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "mret");
    rd(12'h300, 1'b0, 1'b0, "mret_mstatus");

    // 4: timer interrupt deferred by a redirect
    rd(12'h000, 1'b0, 1'b0, "ext_drain");
    wr(12'h304, 32'h80, 2'b01, 1'b0, 1'b0, "wr_mtie");
    cyc(1'b1, 32'h80, 12'h000, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, "timer_busy");
    cyc(1'b1, 32'h84, 12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, "timer_take");
    rd(12'h342, 1'b1, 1'b0, "timer_mcause");

    // 5: both pending, external wins; trap overrides same-cycle mepc write
    wr(12'h304, 32'h880, 2'b01, 1'b1, 1'b1, "wr_mie_both");
    rd(12'h000, 1'b1, 1'b1, "both_sync0");
    rd(12'h000, 1'b1, 1'b1, "both_sync1");
    wr(12'h300, 32'h8, 2'b10, 1'b1, 1'b1, "set_mie");
    cyc(1'b1, 32'h1000, 12'h341, 32'h1234, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, "trap_vs_wr");
    rd(12'h341, 1'b1, 1'b1, "both_mepc");
    rd(12'h342, 1'b1, 1'b1, "both_mcause");

    // 6: set/clear on mie, unmapped write ignored
    wr(12'h304, 32'h0, 2'b01, 1'b0, 1'b0, "mie_zero");
    wr(12'h304, 32'h880, 2'b10, 1'b0, 1'b0, "mie_set");
    wr(12'h304, 32'h880, 2'b11, 1'b0, 1'b0, "mie_clr");
    rd(12'h304, 1'b0, 1'b0, "mie_after_clr");
    wr(12'h7C0, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, "wr_unmapped");
    rd(12'h7C0, 1'b0, 1'b0, "rd_unmapped");
    for (int i = 0; i < 6; i++) rd(six[i], 1'b0, 1'b0, $sformatf("post_unmapped%0d", i));

    // pc wrap on trap: mepc = 0
    wr(12'h304, 32'h80, 2'b01, 1'b0, 1'b0, "wrap_mie");
    wr(12'h300, 32'h8, 2'b01, 1'b0, 1'b0, "wrap_mstatus");
    cyc(1'b1, 32'hFFFF_FFFC, 12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, "wrap_trap");
    rd(12'h341, 1'b0, 1'b0, "wrap_mepc");

    // Randomized traffic, including an occasional mid-stream reset
    tmr = 1'b0; ext = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc, wd;
      logic [11:0] a;
      if ($urandom_range(0, 9) == 0) tmr = ~tmr;
      if ($urandom_range(0, 9) == 0) ext = ~ext;
      pc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
      a  = addrs[$urandom_range(0, 7)];
      wd = $urandom();
      if ($urandom_range(0, 3) == 0) wd = wd & 32'h888;
      cyc(($urandom_range(0, 149) != 0), pc, a, wd, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), tmr, ext,
          $sformatf("rand%0d", i));
    end

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      vectors++;
      if (exp_q.size() > 0) begin
        miscompares++;
        $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
